burst_scheduler: RTL and testbench

Sequences register-bank-driven transfers onto the burst interface, on the data-burst side of the register bank. On a start it splits `length` bytes into bursts of at most `max_burst_size` beats and issues one command per burst. For writes it fetches each byte from the bank's data registers and streams it out. For reads it captures each incoming beat and stores it into the data registers. It owns `db_rb_*` handshaking, `idle` reporting and read-done signalling.

---
 rtl/burst_sched_pkg.sv | 25 ++
 rtl/burst_scheduler_if.sv | 62 ++++++
 rtl/burst_len_calc.sv | 17 +
 rtl/burst_scheduler.sv | 160 ++++++++++++++++
 tb/tb_burst_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_sched_pkg.sv
// Shared types and constants for the burst scheduler: FSM states, register-bank
// map and the burst-size helper.
package burst_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StFetch,
    StWbeat,
    StRbeat,
    StStore,
    StDone
  } state_e;

  localparam int unsigned LENGTH_ADDR         = 256;
  localparam int unsigned MAX_BURST_SIZE_ADDR = 257;
  localparam int unsigned START_REG_ADDR      = 258;
  localparam int unsigned DATA_REGS           = 256;

  // A programmed burst size of zero still moves one beat per burst.
  function automatic logic [7:0] eff_mbs(input logic [7:0] mbs);
    return (mbs == 8'd0) ? 8'd1 : mbs;
  endfunction

endpackage

// File: rtl/burst_scheduler_if.sv
// Register-bank and burst-interface signals of the burst scheduler.
// The master modport is the scheduler side; slave is the bank/burst side.
interface burst_scheduler_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);

  // Register bank -> scheduler
  logic              rb_db_start;
  logic [7:0]        rb_db_length;
  logic [7:0]        rb_db_max_burst_size;
  logic              rb_db_rw;
  logic [DATA_W-1:0] rb_db_data;
  logic              rb_db_ack;

  // Scheduler -> register bank
  logic              db_rb_req;
  logic [ADDR_W-1:0] db_rb_addr;
  logic [DATA_W-1:0] db_rb_data;
  logic              db_rb_idle;
  logic              db_rb_rd_done;

  // Burst command channel
  logic              bi_cmd_valid;
  logic              bi_cmd_ready;
  logic              bi_cmd_rw;
  logic [7:0]        bi_cmd_len;

  // Write beat channel
  logic [DATA_W-1:0] bi_wdata;
  logic              bi_wvalid;
  logic              bi_wready;
  logic              bi_wlast;

  // Read beat channel
  logic [DATA_W-1:0] bi_rdata;
  logic              bi_rvalid;
  logic              bi_rready;

  modport master (
    input  rb_db_start, rb_db_length, rb_db_max_burst_size, rb_db_rw, rb_db_data, rb_db_ack,
    output db_rb_req, db_rb_addr, db_rb_data, db_rb_idle, db_rb_rd_done,
    output bi_cmd_valid, bi_cmd_rw, bi_cmd_len,
    input  bi_cmd_ready,
    output bi_wdata, bi_wvalid, bi_wlast,
    input  bi_wready,
    input  bi_rdata, bi_rvalid,
    output bi_rready
  );

  modport slave (
    output rb_db_start, rb_db_length, rb_db_max_burst_size, rb_db_rw, rb_db_data, rb_db_ack,
    input  db_rb_req, db_rb_addr, db_rb_data, db_rb_idle, db_rb_rd_done,
    input  bi_cmd_valid, bi_cmd_rw, bi_cmd_len,
    output bi_cmd_ready,
    input  bi_wdata, bi_wvalid, bi_wlast,
    output bi_wready,
    output bi_rdata, bi_rvalid,
    input  bi_rready
  );

endinterface

// File: rtl/burst_len_calc.sv
// Length of the next burst: the smaller of the bytes left and the effective
// maximum burst size.
module burst_len_calc (
  input  logic [7:0] rem,
  input  logic [7:0] mbs,
  output logic [7:0] len
);
  import burst_sched_pkg::*;

  logic [7:0] mbs_eff;

  always_comb begin
    mbs_eff = eff_mbs(mbs);
    len     = (rem < mbs_eff) ? rem : mbs_eff;
  end

endmodule

// File: rtl/burst_scheduler.sv
// Splits a register-bank transfer into bursts, moving bytes between the bank's
// data registers and the burst interface one byte every two cycles.
module burst_scheduler #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input logic                clk,
  input logic                rst,
  burst_scheduler_if.master  bus
);
  import burst_sched_pkg::*;

  state_e            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              armed_q, armed_d;

  logic [7:0]        burst_len;
  logic [7:0]        rem_dec;
  logic [7:0]        beat_dec;
  state_e            after_beat;

  burst_len_calc u_len_calc (
    .rem (rem_q),
    .mbs (bus.rb_db_max_burst_size),
    .len (burst_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      armed_q <= armed_d;
    end
  end

  // Where a completed beat leads: next beat of this burst, a new burst, or the end.
  always_comb begin
    rem_dec  = rem_q - 8'd1;
    beat_dec = beat_q - 8'd1;
    if (beat_dec != 8'd0) begin
      after_beat = rw_q ? StFetch : StRbeat;
    end else if (rem_dec != 8'd0) begin
      after_beat = StCmd;
    end else begin
      after_beat = StDone;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    // Re-arm only once the bank has dropped its start flag.
    armed_d = armed_q | ~bus.rb_db_start;

    unique case (state_q)
      StIdle: begin
        if (bus.rb_db_start && armed_q) begin
          armed_d = 1'b0;
          rw_d    = bus.rb_db_rw;
          rem_d   = bus.rb_db_length;
          ptr_d   = '0;
          state_d = (bus.rb_db_length == 8'd0) ? StDone : StCmd;
        end
      end
      StCmd: begin
        if (bus.bi_cmd_ready) begin
          beat_d  = burst_len;
          state_d = rw_q ? StFetch : StRbeat;
        end
      end
      StFetch: begin
        data_d  = bus.rb_db_data;
        state_d = StWbeat;
      end
      StWbeat: begin
        if (bus.bi_wready) begin
          ptr_d   = ptr_q + 8'd1;
          rem_d   = rem_dec;
          beat_d  = beat_dec;
          state_d = after_beat;
        end
      end
      StRbeat: begin
        if (bus.bi_rvalid) begin
          data_d  = bus.bi_rdata;
          state_d = StStore;
        end
      end
      StStore: begin
        ptr_d   = ptr_q + 8'd1;
        rem_d   = rem_dec;
        beat_d  = beat_dec;
        state_d = after_beat;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode registered state only; command fields are zero outside CMD.
  always_comb begin
    bus.db_rb_idle    = (state_q == StIdle);
    bus.db_rb_req     = (state_q == StFetch) || (state_q == StStore);
    bus.db_rb_addr    = ADDR_W'(ptr_q);
    bus.db_rb_data    = data_q;
    bus.db_rb_rd_done = (state_q == StDone) && !rw_q;

    bus.bi_cmd_valid  = (state_q == StCmd);
    bus.bi_cmd_rw     = (state_q == StCmd) && rw_q;
    bus.bi_cmd_len    = (state_q == StCmd) ? burst_len : 8'd0;

    bus.bi_wvalid     = (state_q == StWbeat);
    bus.bi_wdata      = data_q;
    bus.bi_wlast      = (state_q == StWbeat) && (beat_q == 8'd1);

    bus.bi_rready     = (state_q == StRbeat);
  end

`ifndef SYNTHESIS
  // The bank must acknowledge every access in the same cycle.
  a_bank_ack: assert property (@(posedge clk) disable iff (rst)
    bus.db_rb_req |-> bus.rb_db_ack);

  a_ptr_range: assert property (@(posedge clk) disable iff (rst)
    bus.db_rb_req |-> (32'(ptr_q) < DATA_REGS));

  a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.bi_cmd_valid && !bus.bi_cmd_ready) |=>
      (bus.bi_cmd_valid && $stable(bus.bi_cmd_rw)));

  a_w_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.bi_wvalid && !bus.bi_wready) |=>
      (bus.bi_wvalid && $stable(bus.bi_wdata) && $stable(bus.bi_wlast)));
`endif

endmodule

// File: tb/tb_burst_scheduler.sv
// Scoreboard bench for burst_scheduler: a bank model answers fetches, expected
// commands, write beats and bank stores are queued and checked as they occur.
module tb_burst_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  burst_scheduler_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  burst_scheduler #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  bank [256];
  logic [8:0]  exp_cmd [$];
  logic [8:0]  exp_w [$];
  logic [16:0] exp_st [$];
  logic [7:0]  rsrc [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_done_cnt = 0;
  int          cmd_cnt = 0;
  logic        cur_rw = 1'b1;

  assign bus.rb_db_ack  = bus.db_rb_req;
  assign bus.rb_db_data = bank[bus.db_rb_addr[7:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read-beat source: present the head of rsrc whenever it is non-empty.
  initial begin
    bus.bi_rvalid = 1'b0;
    bus.bi_rdata  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.bi_rvalid = (rsrc.size() != 0);
      bus.bi_rdata  = (rsrc.size() != 0) ? rsrc[0] : 8'h00;
    end
  end

  // Monitor: handshakes are sampled mid-cycle and compared against the queues.
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    if (!rst) begin
      if (bus.bi_cmd_valid && bus.bi_cmd_ready) begin
        cmd_cnt++;
        if (exp_cmd.size() == 0) check_eq("cmd_extra", exp_cmd.size(), 1);
        else begin
          e = 17'(exp_cmd.pop_front());
          check_eq("cmd", {bus.bi_cmd_rw, bus.bi_cmd_len}, 32'(e));
        end
      end
      if (bus.bi_wvalid && bus.bi_wready) begin
        if (exp_w.size() == 0) check_eq("wbeat_extra", exp_w.size(), 1);
        else begin
          e = 17'(exp_w.pop_front());
          check_eq("wbeat", {bus.bi_wlast, bus.bi_wdata}, 32'(e));
        end
      end
      if (bus.db_rb_req && !cur_rw) begin
        if (exp_st.size() == 0) check_eq("store_extra", exp_st.size(), 1);
        else begin
          e = exp_st.pop_front();
          check_eq("store", {bus.db_rb_addr, bus.db_rb_data}, 32'(e));
        end
      end
      if (bus.bi_rvalid && bus.bi_rready) void'(rsrc.pop_front());
      if (bus.db_rb_rd_done) rd_done_cnt++;
    end
  end

  task automatic start_xfer(input logic rw, input logic [7:0] len, input logic [7:0] mbs,
                            input logic hold, input string tag);
    @(posedge clk);
    #1;
    cur_rw                   = rw;
    bus.rb_db_rw             = rw;
    bus.rb_db_length         = len;
    bus.rb_db_max_burst_size = mbs;
    bus.rb_db_start          = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_idle_low"}, bus.db_rb_idle, 0);
    if (len != 8'd0) check_eq({tag, "_cmd_valid"}, bus.bi_cmd_valid, 1);
    if (!hold) bus.rb_db_start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int busy);
    busy = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.db_rb_idle) break;
      busy++;
    end
    check_eq("idle_reached", bus.db_rb_idle, 1);
  endtask

  task automatic check_queues(input string tag);
    check_eq({tag, "_cmd_left"}, exp_cmd.size(), 0);
    check_eq({tag, "_w_left"}, exp_w.size(), 0);
    check_eq({tag, "_st_left"}, exp_st.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int base_rd;
    int base_cmd;
    int found;

    rst                      = 1'b1;
    bus.rb_db_start          = 1'b0;
    bus.rb_db_length         = 8'd0;
    bus.rb_db_max_burst_size = 8'd0;
    bus.rb_db_rw             = 1'b0;
    bus.bi_cmd_ready         = 1'b1;
    bus.bi_wready            = 1'b1;
    for (int i = 0; i < 256; i++) bank[i] = 8'(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_idle", bus.db_rb_idle, 1);
    check_eq("rst_req", bus.db_rb_req, 0);
    check_eq("rst_rd_done", bus.db_rb_rd_done, 0);
    check_eq("rst_addr", bus.db_rb_addr, 0);
    check_eq("rst_rb_data", bus.db_rb_data, 0);
    check_eq("rst_cmd_valid", bus.bi_cmd_valid, 0);
    check_eq("rst_cmd_len", bus.bi_cmd_len, 0);
    check_eq("rst_wvalid", bus.bi_wvalid, 0);
    check_eq("rst_wlast", bus.bi_wlast, 0);
    check_eq("rst_wdata", bus.bi_wdata, 0);
    check_eq("rst_rready", bus.bi_rready, 0);
    rst = 1'b0;

    // Write, length 5, mbs 2
    for (int i = 0; i < 5; i++) bank[i] = 8'h10 + 8'(i);
    exp_cmd.push_back({1'b1, 8'd2});
    exp_cmd.push_back({1'b1, 8'd2});
    exp_cmd.push_back({1'b1, 8'd1});
    exp_w.push_back({1'b0, 8'h10});
    exp_w.push_back({1'b1, 8'h11});
    exp_w.push_back({1'b0, 8'h12});
    exp_w.push_back({1'b1, 8'h13});
    exp_w.push_back({1'b1, 8'h14});
    base_rd = rd_done_cnt;
    start_xfer(1'b1, 8'd5, 8'd2, 1'b0, "wr5");
    wait_idle(200, busy);
    check_eq("wr5_busy_cycles", busy, 14);
    check_eq("wr5_no_rd_done", rd_done_cnt, base_rd);
    check_queues("wr5");

    // Read, length 3, mbs 4
    rsrc.push_back(8'hA0);
    rsrc.push_back(8'hA1);
    rsrc.push_back(8'hA2);
    exp_cmd.push_back({1'b0, 8'd3});
    for (int i = 0; i < 3; i++) exp_st.push_back({9'(i), 8'hA0 + 8'(i)});
    base_rd = rd_done_cnt;
    start_xfer(1'b0, 8'd3, 8'd4, 1'b0, "rd3");
    wait_idle(200, busy);
    check_eq("rd3_busy_cycles", busy, 8);
    check_eq("rd3_rd_done", rd_done_cnt, base_rd + 1);
    check_queues("rd3");

    // Empty read
    base_rd  = rd_done_cnt;
    base_cmd = cmd_cnt;
    start_xfer(1'b0, 8'd0, 8'd4, 1'b0, "rd0");
    check_eq("rd0_rd_done_pulse", bus.db_rb_rd_done, 1);
    check_eq("rd0_no_cmd", bus.bi_cmd_valid, 0);
    wait_idle(20, busy);
    check_eq("rd0_busy_cycles", busy, 1);
    check_eq("rd0_rd_done_cnt", rd_done_cnt, base_rd + 1);
    check_eq("rd0_cmd_cnt", cmd_cnt, base_cmd);

    // mbs 0, length 3 write with stalls; start held high throughout
    bank[0] = 8'h55;
    bank[1] = 8'h66;
    bank[2] = 8'h77;
    for (int i = 0; i < 3; i++) exp_cmd.push_back({1'b1, 8'd1});
    exp_w.push_back({1'b1, 8'h55});
    exp_w.push_back({1'b1, 8'h66});
    exp_w.push_back({1'b1, 8'h77});
    bus.bi_cmd_ready = 1'b0;
    bus.bi_wready    = 1'b0;
    start_xfer(1'b1, 8'd3, 8'd0, 1'b1, "mbs0");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_cmd_valid", bus.bi_cmd_valid, 1);
      check_eq("stall_cmd_fields", {bus.bi_cmd_rw, bus.bi_cmd_len}, {1'b1, 8'd1});
    end
    @(posedge clk);
    #1;
    bus.bi_cmd_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.bi_wvalid) begin
        found = 1;
        break;
      end
    end
    check_eq("stall_wvalid_seen", found, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_wvalid", bus.bi_wvalid, 1);
      check_eq("stall_wbeat", {bus.bi_wlast, bus.bi_wdata}, {1'b1, 8'h55});
      check_eq("stall_ptr", bus.db_rb_addr, 0);
    end
    @(posedge clk);
    #1;
    bus.bi_wready = 1'b1;
    wait_idle(200, busy);
    check_queues("mbs0");
    base_cmd = cmd_cnt;
    repeat (6) @(negedge clk);
    check_eq("no_retrigger_idle", bus.db_rb_idle, 1);
    check_eq("no_retrigger_cmds", cmd_cnt, base_cmd);
    bus.rb_db_start = 1'b0;

    // Reset during the second beat, then restart from address 0
    for (int i = 0; i < 4; i++) bank[i] = 8'h30 + 8'(i);
    exp_cmd.push_back({1'b1, 8'd4});
    for (int i = 0; i < 4; i++) exp_w.push_back({i == 3, 8'h30 + 8'(i)});
    start_xfer(1'b1, 8'd4, 8'd4, 1'b0, "rst1");
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.bi_wvalid && bus.db_rb_addr == 9'd1) begin
        found = 1;
        break;
      end
    end
    check_eq("rst_second_beat_seen", found, 1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_idle", bus.db_rb_idle, 1);
    check_eq("mid_rst_wvalid", bus.bi_wvalid, 0);
    check_eq("mid_rst_wlast", bus.bi_wlast, 0);
    check_eq("mid_rst_wdata", bus.bi_wdata, 0);
    check_eq("mid_rst_cmd_valid", bus.bi_cmd_valid, 0);
    check_eq("mid_rst_req", bus.db_rb_req, 0);
    check_eq("mid_rst_addr", bus.db_rb_addr, 0);
    exp_cmd.delete();
    exp_w.delete();
    exp_st.delete();
    rsrc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cmd.push_back({1'b1, 8'd4});
    for (int i = 0; i < 4; i++) exp_w.push_back({i == 3, 8'h30 + 8'(i)});
    start_xfer(1'b1, 8'd4, 8'd4, 1'b0, "rst2");
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.db_rb_req) begin
        found = 1;
        break;
      end
    end
    check_eq("restart_req_seen", found, 1);
    check_eq("restart_addr", bus.db_rb_addr, 0);
    wait_idle(200, busy);
    check_queues("rst2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
